combo_lock_fsm: RTL and testbench
=================================

COMBO_LOCK_FSM -- requirements
Module: combo_lock_fsm

Interface
REQ-001 Parameter DEFAULT_CODE, default 16'h1234, the stored combination loaded at reset, four hex digits with the first-entered digit in [15:12].
REQ-002 Parameter MAX_FAILS, default 3, the number of consecutive wrong combinations that triggers lockout; legal range 1..7.
REQ-003 Parameter LOCKOUT_CYCLES, default 100_000_000 (1 s at 100 MHz), the lockout duration in clk cycles; legal range >= 2.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in  input  4  digit value sampled on trig.
REQ-007 trig  input  1  debounced single-cycle digit-entry pulse.
REQ-008 prog  input  1  level; when high at the 4th digit in OPEN, commits a new combination.
REQ-009 entered  output  16  digits entered so far, newest in [3:0], for the seven-segment display.
REQ-010 digitCount  output  3  number of digits entered in the current attempt, 0..4.
REQ-011 unlocked  output  1  high only in state OPEN.
REQ-012 lockedOut  output  1  high only in state ALARM.
REQ-013 failCount  output  3  consecutive wrong attempts since the last success or lockout expiry.

Function
REQ-014 States: LOCKED, CHECK, OPEN, ALARM; all outputs are registered.
REQ-015 LOCKED: on trig, entered <= {entered[11:0], in} and digitCount increments in the same cycle; on the 4th trig, next state is CHECK.
REQ-016 CHECK lasts exactly one cycle and compares entered with the stored code.
REQ-017 On match: next state is OPEN, failCount <= 0, entered and digitCount cleared; unlocked rises 2 cycles after the 4th trig.
REQ-018 On mismatch: failCount increments; if the new value equals MAX_FAILS, next state is ALARM, otherwise LOCKED; entered and digitCount are cleared in both cases.
REQ-019 trig asserted during CHECK is ignored.
REQ-020 OPEN: digits shift in as in LOCKED; on the 4th trig, if prog=1 the stored code <= the new 16-bit value (the shifted result including the 4th digit); the next state is LOCKED regardless of prog, with entered and digitCount cleared.
REQ-021 ALARM: a down-counter loaded with LOCKOUT_CYCLES-1 on entry decrements each cycle; trig is ignored; at count 0, next state is LOCKED and failCount <= 0.
REQ-022 trig with digitCount < 4 never changes the state; prog outside the 4th digit in OPEN has no effect.
REQ-023 The stored code changes only per REQ-020 or reset.

Reset
REQ-024 rst asserted at any time forces state LOCKED, stored code DEFAULT_CODE, entered 0, digitCount 0, failCount 0, unlocked 0, lockedOut 0, lockout counter 0, immediately and without waiting for clk.
REQ-025 Reset mid-attempt, mid-OPEN or mid-lockout discards all progress; an in-progress reprogram is not committed.

Structure
REQ-026 State encoding and DEFAULT_CODE belong in a shared combo_lock_pkg package used by the top-level and the testbench.
REQ-027 The lockout timer is one sub-module, lockout_timer (load, count-down, done pulse); all else is flat.

Verification
REQ-028 Reset, then trig with in = 1, 2, 3, 4 -> unlocked=1 two cycles after the 4th trig, failCount=0.
REQ-029 Enter 1,2,3,5 three times -> failCount 1, then 2, then lockedOut=1; trig during ALARM -> no change in entered; after LOCKOUT_CYCLES (set to 16) -> LOCKED, failCount=0.
REQ-030 In OPEN, enter A,B,C,D with prog=1 -> return to LOCKED; 1,2,3,4 -> mismatch; A,B,C,D -> unlocked=1.
REQ-031 In OPEN, enter 9,9,9,9 with prog=0 -> LOCKED, code still 1234.
REQ-032 Assert rst after 2 digits, and again mid-lockout -> all outputs return to reset values asynchronously, and the code equals DEFAULT_CODE.
REQ-033 Two wrong attempts then the correct code -> OPEN with failCount=0; a further wrong attempt gives failCount=1, not lockout.

Source files
------------

// File: rtl/combo_lock_pkg.sv
// Shared definitions for the four-digit combination lock: state names,
// factory combination and digit-shift helper.
package combo_lock_pkg;

   typedef enum logic [1:0] {
      LOCKED = 2'd0,
      CHECK  = 2'd1,
      OPEN   = 2'd2,
      ALARM  = 2'd3
   } state_t;

   localparam logic [15:0] DEFAULT_CODE = 16'h1234;
   localparam int unsigned CODE_DIGITS  = 4;

   // Newest digit enters at the bottom nibble, oldest falls off the top.
   function automatic logic [15:0] shift_digit(input logic [15:0] cur, input logic [3:0] d);
      return {cur[11:0], d};
   endfunction

endpackage

// File: rtl/lockout_timer.sv
// Lockout down-counter: load sets CYCLES-1, en counts toward zero,
// done is high for the enabled cycle in which the count sits at zero.
module lockout_timer #(
   parameter int unsigned CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam int unsigned CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = en && !load && (cnt_q == '0);

endmodule

// File: rtl/combo_lock_fsm.sv
// Four-digit combination lock with reprogramming from OPEN and a timed
// lockout after MAX_FAILS consecutive wrong attempts; all outputs registered.
module combo_lock_fsm #(
   parameter logic [15:0] DEFAULT_CODE   = combo_lock_pkg::DEFAULT_CODE,
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  in,
   input  logic        trig,
   input  logic        prog,
   output logic [15:0] entered,
   output logic [2:0]  digitCount,
   output logic        unlocked,
   output logic        lockedOut,
   output logic [2:0]  failCount
);

   import combo_lock_pkg::*;

   localparam logic [2:0] MAX_FAILS_V = 3'(MAX_FAILS);
   localparam logic [2:0] LAST_IDX    = 3'(CODE_DIGITS - 1);

   state_t      state_q, state_d;
   logic [15:0] code_q, code_d;
   logic [15:0] entered_q, entered_d;
   logic [2:0]  digit_cnt_q, digit_cnt_d;
   logic [2:0]  fail_q, fail_d;
   logic        unlocked_q, unlocked_d;
   logic        locked_out_q, locked_out_d;

   logic [15:0] shifted;
   logic        last_digit;
   logic        timer_load;
   logic        timer_en;
   logic        timer_done;

   lockout_timer #(
      .CYCLES (LOCKOUT_CYCLES)
   ) u_lockout_timer (
      .clk  (clk),
      .rst  (rst),
      .load (timer_load),
      .en   (timer_en),
      .done (timer_done)
   );

   assign shifted    = shift_digit(entered_q, in);
   assign last_digit = trig && (digit_cnt_q == LAST_IDX);
   assign timer_en   = (state_q == ALARM);

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      entered_d   = entered_q;
      digit_cnt_d = digit_cnt_q;
      fail_d      = fail_q;
      timer_load  = 1'b0;

      case (state_q)
         LOCKED: begin
            if (trig) begin
               entered_d   = shifted;
               digit_cnt_d = digit_cnt_q + 3'd1;
               if (last_digit) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            entered_d   = '0;
            digit_cnt_d = '0;
            if (entered_q == code_q) begin
               state_d = OPEN;
               fail_d  = '0;
            end else begin
               fail_d = fail_q + 3'd1;
               if (fail_d == MAX_FAILS_V) begin
                  state_d    = ALARM;
                  timer_load = 1'b1;
               end else begin
                  state_d = LOCKED;
               end
            end
         end
         OPEN: begin
            if (last_digit) begin
               // The commit uses the shifted value so the 4th digit is included.
               if (prog) begin
                  code_d = shifted;
               end
               entered_d   = '0;
               digit_cnt_d = '0;
               state_d     = LOCKED;
            end else if (trig) begin
               entered_d   = shifted;
               digit_cnt_d = digit_cnt_q + 3'd1;
            end
         end
         ALARM: begin
            if (timer_done) begin
               state_d = LOCKED;
               fail_d  = '0;
            end
         end
         default: begin
            state_d = LOCKED;
         end
      endcase

      unlocked_d   = (state_d == OPEN);
      locked_out_d = (state_d == ALARM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LOCKED;
         code_q       <= DEFAULT_CODE;
         entered_q    <= '0;
         digit_cnt_q  <= '0;
         fail_q       <= '0;
         unlocked_q   <= 1'b0;
         locked_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         entered_q    <= entered_d;
         digit_cnt_q  <= digit_cnt_d;
         fail_q       <= fail_d;
         unlocked_q   <= unlocked_d;
         locked_out_q <= locked_out_d;
      end
   end

   assign entered    = entered_q;
   assign digitCount = digit_cnt_q;
   assign unlocked   = unlocked_q;
   assign lockedOut  = locked_out_q;
   assign failCount  = fail_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Bench for combo_lock_fsm: directed scenarios plus random traffic, checked
// every cycle against a digit-queue model of the lock's rules.
module tb_combo_lock_fsm;

   import combo_lock_pkg::*;

   localparam int unsigned MAXF = 3;
   localparam int unsigned LOCK = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  in = '0;
   logic        trig = 1'b0;
   logic        prog = 1'b0;
   logic [15:0] entered;
   logic [2:0]  digitCount;
   logic        unlocked;
   logic        lockedOut;
   logic [2:0]  failCount;

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   combo_lock_fsm #(
      .DEFAULT_CODE   (DEFAULT_CODE),
      .MAX_FAILS      (MAXF),
      .LOCKOUT_CYCLES (LOCK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in         (in),
      .trig       (trig),
      .prog       (prog),
      .entered    (entered),
      .digitCount (digitCount),
      .unlocked   (unlocked),
      .lockedOut  (lockedOut),
      .failCount  (failCount)
   );

   initial forever #5 clk = ~clk;

   // Model: the attempt is a queue of digits; the lock is a mode plus a
   // remaining-lockout count measured in whole cycles.
   state_t      m_mode;
   logic [15:0] m_code;
   int          m_digits[$];
   int          m_fails;
   int          m_left;

   function automatic logic [15:0] pack_digits();
      int v = 0;
      foreach (m_digits[i]) v = v * 16 + m_digits[i];
      return 16'(v);
   endfunction

   task automatic model_step();
      logic [15:0] v;
      case (m_mode)
         LOCKED: if (trig) begin
            m_digits.push_back(int'(in));
            if (m_digits.size() == 4) m_mode = CHECK;
         end
         CHECK: begin
            v = pack_digits();
            m_digits.delete();
            if (v == m_code) begin
               m_mode  = OPEN;
               m_fails = 0;
            end else begin
               m_fails = m_fails + 1;
               if (m_fails == int'(MAXF)) begin
                  m_mode = ALARM;
                  m_left = LOCK;
               end else begin
                  m_mode = LOCKED;
               end
            end
         end
         OPEN: if (trig) begin
            m_digits.push_back(int'(in));
            if (m_digits.size() == 4) begin
               if (prog) m_code = pack_digits();
               m_digits.delete();
               m_mode = LOCKED;
            end
         end
         default: begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_mode  = LOCKED;
               m_fails = 0;
            end
         end
      endcase
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode  = LOCKED;
         m_code  = DEFAULT_CODE;
         m_digits.delete();
         m_fails = 0;
         m_left  = 0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         n_cmp++;
         if (entered !== pack_digits() || digitCount !== 3'(m_digits.size()) ||
             unlocked !== (m_mode == OPEN) || lockedOut !== (m_mode == ALARM) ||
             failCount !== 3'(m_fails)) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t: got ent=%h cnt=%0d unl=%b lo=%b fc=%0d expected ent=%h cnt=%0d unl=%b lo=%b fc=%0d",
                     $time, entered, digitCount, unlocked, lockedOut, failCount,
                     pack_digits(), m_digits.size(), (m_mode == OPEN), (m_mode == ALARM), m_fails);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] d, input logic p);
      in   = d;
      trig = 1'b1;
      prog = p;
      @(negedge clk);
      trig = 1'b0;
      prog = 1'b0;
      in   = '0;
   endtask

   task automatic enter4(input logic [15:0] c, input logic p);
      for (int i = 3; i >= 0; i--) press(c[i*4 +: 4], p);
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1;
      check("async_rst_entered", 32'(entered), 32'h0);
      check("async_rst_outputs", {27'd0, digitCount, unlocked, lockedOut}, 32'h0);
      check("async_rst_fails", 32'(failCount), 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_unlock_expiry(input string name);
      int k = 0;
      while (lockedOut === 1'b1 && k < 4 * LOCK) begin
         idle(1);
         k++;
      end
      check(name, 32'(lockedOut), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] dig;
      int         idx;

      #1 rst = 1'b1;
      #1;
      check("reset_entered", 32'(entered), 32'h0);
      check("reset_flags", {27'd0, digitCount, unlocked, lockedOut}, 32'h0);
      check("reset_fails", 32'(failCount), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      checking = 1'b1;
      idle(2);

      // Correct code from reset.
      press(4'h1, 1'b0);
      check("first_digit_entered", 32'(entered), 32'h0001);
      check("first_digit_count", 32'(digitCount), 32'd1);
      press(4'h2, 1'b0);
      press(4'h3, 1'b0);
      press(4'h4, 1'b0);
      check("check_entered", 32'(entered), 32'h1234);
      check("check_count", 32'(digitCount), 32'd4);
      check("not_yet_open", 32'(unlocked), 32'h0);
      idle(1);
      check("open_after_2", 32'(unlocked), 32'h1);
      check("open_fails", 32'(failCount), 32'h0);
      check("open_cleared", 32'(entered), 32'h0);

      // Leaving OPEN without prog keeps the code.
      enter4(16'h9999, 1'b0);
      check("leave_open", 32'(unlocked), 32'h0);
      enter4(16'h1234, 1'b0);
      idle(1);
      check("code_kept", 32'(unlocked), 32'h1);

      // Reprogram to ABCD, old code rejected, new code accepted, restore.
      enter4(16'hABCD, 1'b1);
      check("prog_to_locked", 32'(unlocked), 32'h0);
      enter4(16'h1234, 1'b0);
      idle(1);
      check("old_code_rejected", {30'd0, unlocked, lockedOut}, 32'h0);
      check("old_code_fail", 32'(failCount), 32'd1);
      enter4(16'hABCD, 1'b0);
      idle(1);
      check("new_code_open", 32'(unlocked), 32'h1);
      check("new_code_fails", 32'(failCount), 32'h0);
      enter4(16'h1234, 1'b1);

      // Three wrong attempts -> lockout, trig ignored, expiry.
      enter4(16'h1235, 1'b0);
      idle(1);
      check("wrong1_fails", 32'(failCount), 32'd1);
      enter4(16'h1235, 1'b0);
      idle(1);
      check("wrong2_fails", 32'(failCount), 32'd2);
      enter4(16'h1235, 1'b0);
      idle(1);
      check("alarm_on", 32'(lockedOut), 32'h1);
      check("alarm_fails", 32'(failCount), 32'd3);
      press(4'h7, 1'b0);
      check("alarm_ignores_trig", 32'(entered), 32'h0);
      wait_unlock_expiry("alarm_expiry");
      check("expiry_fails", 32'(failCount), 32'h0);

      // Two wrong then right; one more wrong is not a lockout.
      enter4(16'h4321, 1'b0);
      idle(1);
      enter4(16'h0000, 1'b0);
      idle(1);
      enter4(16'h1234, 1'b0);
      idle(1);
      check("recover_open", 32'(unlocked), 32'h1);
      check("recover_fails", 32'(failCount), 32'h0);
      enter4(16'h5555, 1'b0);
      enter4(16'h8888, 1'b0);
      idle(1);
      check("single_wrong_fails", 32'(failCount), 32'd1);
      check("single_wrong_no_alarm", 32'(lockedOut), 32'h0);

      // Reset mid-attempt, mid-reprogram and mid-lockout.
      press(4'h1, 1'b0);
      press(4'h2, 1'b0);
      pulse_reset();
      enter4(16'h1234, 1'b0);
      idle(1);
      press(4'hA, 1'b1);
      press(4'hB, 1'b1);
      press(4'hC, 1'b1);
      pulse_reset();
      for (int a = 0; a < 3; a++) begin
         enter4(16'h0F0F, 1'b0);
         idle(1);
      end
      idle(5);
      check("mid_lockout_alarm", 32'(lockedOut), 32'h1);
      pulse_reset();
      enter4(16'h1234, 1'b0);
      idle(1);
      check("default_code_after_rst", 32'(unlocked), 32'h1);

      // Random traffic, digits biased toward the current code.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulse_reset();
         end else begin
            idx = m_digits.size();
            if (idx < 4 && $urandom_range(0, 3) != 0) dig = m_code[(3 - idx) * 4 +: 4];
            else dig = 4'($urandom_range(0, 15));
            in   = dig;
            trig = ($urandom_range(0, 2) == 0);
            prog = ($urandom_range(0, 4) == 0);
            @(negedge clk);
         end
      end
      trig = 1'b0;
      prog = 1'b0;
      idle(2);

      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
